// File: rtl/find_best_pkg.sv
// Shared encodings and default constants for the find_best_q neighbour search.
package find_best_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_RD_CNT  = 3'd1;
    localparam state_t S_CAP_CNT = 3'd2;
    localparam state_t S_SCAN    = 3'd3;
    localparam state_t S_K_CALC  = 3'd4;
    localparam state_t S_RD_HCM  = 3'd5;
    localparam state_t S_MUL     = 3'd6;
    localparam state_t S_DONE    = 3'd7;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    localparam int Q_FRAC_DEF      = 5;
    localparam int BATT_FRAC_DEF   = 15;
    localparam int NCOUNT_ADDR_DEF = 'h068A;
    localparam int QVAL_BASE_DEF   = 'h01C8;
    localparam int HCM_BASE_DEF    = 'h0648;

endpackage

// File: rtl/fxp_mul_sat.sv
// Unsigned fixed-point multiply: drops FRAC fractional bits and saturates to
// all-ones when the scaled product does not fit in WIDTH bits.
module fxp_mul_sat #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 5
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] shifted;

    always_comb begin
        product = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
        shifted = product >> FRAC;
        if (shifted > {{WIDTH{1'b0}}, {WIDTH{1'b1}}}) begin
            y_o = '1;
        end else begin
            y_o = shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/find_best_q.sv
// Scans up to MAX_NEIGHBORS q-values from memory for the min or max entry,
// then scales it by a battery-indexed HCM factor.
module find_best_q
    import find_best_pkg::*;
#(
    parameter int WORD_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int Q_FRAC        = Q_FRAC_DEF,
    parameter int BATT_FRAC     = BATT_FRAC_DEF,
    parameter int HCM_LENGTH    = 11,
    parameter int MAX_NEIGHBORS = 32,
    parameter int NCOUNT_ADDR   = NCOUNT_ADDR_DEF,
    parameter int QVAL_BASE     = QVAL_BASE_DEF,
    parameter int HCM_BASE      = HCM_BASE_DEF,
    parameter int ADDR_STRIDE   = 2
) (
    input  logic                             clock,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             mode,
    input  logic [WORD_WIDTH-1:0]            data_in,
    input  logic [WORD_WIDTH-1:0]            battery,
    output logic [ADDR_WIDTH-1:0]            address,
    output logic                             busy,
    output logic                             done,
    output logic                             best_valid,
    output logic [WORD_WIDTH-1:0]            best_q,
    output logic [$clog2(MAX_NEIGHBORS)-1:0] best_idx,
    output logic [WORD_WIDTH-1:0]            mybest
);

    localparam int IDX_W = $clog2(MAX_NEIGHBORS);
    localparam int CNT_W = $clog2(MAX_NEIGHBORS + 1);
    localparam int K_W   = $clog2(HCM_LENGTH);
    localparam int P_W   = WORD_WIDTH + 16;
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

    state_t                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [WORD_WIDTH-1:0]   batt_q, batt_d;
    logic [CNT_W-1:0]        n_q, n_d;
    logic [IDX_W-1:0]        j_q, j_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_WIDTH-1:0]   best_q_q, best_q_d;
    logic [IDX_W-1:0]        best_idx_q, best_idx_d;
    logic                    best_valid_q, best_valid_d;
    logic [WORD_WIDTH-1:0]   mybest_q, mybest_d;

    logic [CNT_W-1:0]        n_cap;
    logic                    better;
    logic                    scan_last;
    logic                    addr_more;
    logic [P_W-1:0]          batt_prod;
    logic [P_W-1:0]          k_sum;
    logic [K_W-1:0]          k_clamp;
    logic [ADDR_WIDTH-1:0]   hcm_addr;
    logic [WORD_WIDTH-1:0]   mul_y;

    fxp_mul_sat #(
        .WIDTH (WORD_WIDTH),
        .FRAC  (Q_FRAC)
    ) u_mul (
        .a_i (best_q_q),
        .b_i (data_in),
        .y_o (mul_y)
    );

    // k = ceil((HCM_LENGTH-1) * battery) in integer units, clamped to the last entry.
    always_comb begin
        batt_prod = P_W'(batt_q) * P_W'(HCM_LENGTH - 1);
        k_sum     = (batt_prod >> BATT_FRAC) + P_W'(|batt_prod[BATT_FRAC-1:0]);
        k_clamp   = (k_sum > P_W'(HCM_LENGTH - 1)) ? K_W'(HCM_LENGTH - 1) : K_W'(k_sum);
        hcm_addr  = ADDR_WIDTH'(HCM_BASE) + STRIDE * ADDR_WIDTH'(k_clamp);
    end

    always_comb begin
        n_cap     = (data_in > WORD_WIDTH'(MAX_NEIGHBORS)) ? CNT_W'(MAX_NEIGHBORS)
                                                           : CNT_W'(data_in);
        better    = (mode_q == MODE_MIN) ? (data_in < best_q_q) : (data_in > best_q_q);
        scan_last = ((CNT_W+1)'(j_q) + (CNT_W+1)'(1)) == (CNT_W+1)'(n_q);
        addr_more = ((CNT_W+1)'(j_q) + (CNT_W+1)'(2)) < (CNT_W+1)'(n_q);
    end

    // NOTE: every next-state variable gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        batt_d       = batt_q;
        n_d          = n_q;
        j_d          = j_q;
        addr_d       = addr_q;
        best_q_d     = best_q_q;
        best_idx_d   = best_idx_q;
        best_valid_d = best_valid_q;
        mybest_d     = mybest_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD_CNT;
                    mode_d  = mode;
                    batt_d  = battery;
                    addr_d  = ADDR_WIDTH'(NCOUNT_ADDR);
                end
            end
            S_RD_CNT: begin
                state_d = S_CAP_CNT;
                addr_d  = ADDR_WIDTH'(QVAL_BASE);
            end
            S_CAP_CNT: begin
                n_d          = n_cap;
                j_d          = '0;
                best_idx_d   = '0;
                best_valid_d = 1'b0;
                if (n_cap == '0) begin
                    state_d  = S_DONE;
                    best_q_d = '0;
                    mybest_d = '1;
                end else begin
                    state_d = S_SCAN;
                    if (mode_q == MODE_MIN) begin
                        best_q_d = '1;
                    end else begin
                        best_q_d = '0;
                    end
                    if (n_cap > CNT_W'(1)) begin
                        addr_d = addr_q + STRIDE;
                    end
                end
            end
            S_SCAN: begin
                // Address runs one word ahead of data_in and stops at the last entry.
                best_valid_d = 1'b1;
                if (better) begin
                    best_q_d   = data_in;
                    best_idx_d = j_q;
                end
                if (addr_more) begin
                    addr_d = addr_q + STRIDE;
                end
                if (scan_last) begin
                    state_d = S_K_CALC;
                end else begin
                    j_d = j_q + IDX_W'(1);
                end
            end
            S_K_CALC: begin
                state_d = S_RD_HCM;
                addr_d  = hcm_addr;
            end
            S_RD_HCM: state_d = S_MUL;
            S_MUL: begin
                state_d  = S_DONE;
                mybest_d = mul_y;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_MIN;
            batt_q       <= '0;
            n_q          <= '0;
            j_q          <= '0;
            addr_q       <= ADDR_WIDTH'(NCOUNT_ADDR);
            best_q_q     <= '0;
            best_idx_q   <= '0;
            best_valid_q <= 1'b0;
            mybest_q     <= '1;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            batt_q       <= batt_d;
            n_q          <= n_d;
            j_q          <= j_d;
            addr_q       <= addr_d;
            best_q_q     <= best_q_d;
            best_idx_q   <= best_idx_d;
            best_valid_q <= best_valid_d;
            mybest_q     <= mybest_d;
        end
    end

    assign address    = addr_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign best_valid = best_valid_q;
    assign best_q     = best_q_q;
    assign best_idx   = best_idx_q;
    assign mybest     = mybest_q;

endmodule

// File: tb/tb_find_best_q.sv
// Directed bench for find_best_q with a one-cycle-latency memory model.
module tb_find_best_q;

    logic        clock;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] data_in;
    logic [15:0] battery;
    logic [15:0] address;
    logic        busy;
    logic        done;
    logic        best_valid;
    logic [15:0] best_q;
    logic [4:0]  best_idx;
    logic [15:0] mybest;

    logic [15:0] mem [0:2047];
    logic [15:0] hcm_seen;
    logic [15:0] max_qaddr;
    int          checks;
    int          errors;
    int          cyc;

    find_best_q dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .data_in    (data_in),
        .battery    (battery),
        .address    (address),
        .busy       (busy),
        .done       (done),
        .best_valid (best_valid),
        .best_q     (best_q),
        .best_idx   (best_idx),
        .mybest     (mybest)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) data_in <= mem[address[10:0]];

    // Track the HCM address issued and the highest q-value address issued.
    always @(negedge clock) begin
        if (busy && address >= 16'h0648) hcm_seen = address;
        if (busy && address >= 16'h01C8 && address < 16'h0648 && address > max_qaddr)
            max_qaddr = address;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request; optionally pulse a conflicting start at cycle inject_at.
    task automatic run(input logic m, input logic [15:0] batt, input int inject_at,
                       output int c_done);
        c_done    = -1;
        hcm_seen  = 16'h0000;
        max_qaddr = 16'h0000;
        @(negedge clock);
        start = 1'b1; mode = m; battery = batt;
        @(posedge clock);
        #1 start = 1'b0; mode = 1'b0; battery = 16'h0000;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clock);
            if (c == inject_at) begin
                start = 1'b1; mode = ~m; battery = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                c_done = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int c_exp, input logic v,
                                 input logic [15:0] q, input logic [4:0] idx,
                                 input logic [15:0] mb);
        check({tag, "_latency"}, cyc, c_exp);
        check({tag, "_valid"}, best_valid, v);
        check({tag, "_best_q"}, best_q, q);
        check({tag, "_idx"}, best_idx, idx);
        check({tag, "_mybest"}, mybest, mb);
        @(negedge clock);
        check({tag, "_done_pulse"}, {busy, done}, 2'b00);
        check({tag, "_hold"}, best_q, q);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"}, address, 16'h068A);
        check({tag, "_busy_done"}, {busy, done}, 2'b00);
        check({tag, "_valid"}, best_valid, 1'b0);
        check({tag, "_best_q"}, best_q, 16'h0000);
        check({tag, "_idx"}, best_idx, 5'd0);
        check({tag, "_mybest"}, mybest, 16'hFFFF);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; mode = 1'b0; battery = 16'h0000;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        // HCM entries at 0x0648 + 2k
        mem[11'h648] = 16'h0020;
        mem[11'h652] = 16'h0040;
        mem[11'h654] = 16'h0080;
        mem[11'h65C] = 16'h0400;

        repeat (2) @(negedge clock);
        check_reset_values("reset");

        // Release reset just before an edge where start is already presented.
        mem[11'h68A] = 16'd3;
        mem[11'h1C8] = 16'h0040; mem[11'h1CA] = 16'h0020; mem[11'h1CC] = 16'h0030;
        @(posedge clock); #1 rst = 1'b0;
        run(1'b0, 16'h4000, 0, cyc);
        check("min_hcm_addr", hcm_seen, 16'h0652);
        check("min_max_qaddr", max_qaddr, 16'h01CC);
        expect_result("min", 9, 1'b1, 16'h0020, 5'd1, 16'h0040);

        run(1'b1, 16'h4000, 0, cyc);
        expect_result("max", 9, 1'b1, 16'h0040, 5'd0, 16'h0080);

        mem[11'h68A] = 16'd2;
        mem[11'h1C8] = 16'h0010; mem[11'h1CA] = 16'h0010;
        run(1'b0, 16'h4000, 0, cyc);
        expect_result("tie_min", 8, 1'b1, 16'h0010, 5'd0, 16'h0020);
        run(1'b1, 16'h4000, 0, cyc);
        expect_result("tie_max", 8, 1'b1, 16'h0010, 5'd0, 16'h0020);

        mem[11'h68A] = 16'd0;
        run(1'b0, 16'h4000, 0, cyc);
        expect_result("empty", 3, 1'b0, 16'h0000, 5'd0, 16'hFFFF);

        mem[11'h68A] = 16'd3;
        mem[11'h1C8] = 16'h0040; mem[11'h1CA] = 16'h0020; mem[11'h1CC] = 16'h0030;
        run(1'b0, 16'h4001, 0, cyc);
        check("round_hcm_addr", hcm_seen, 16'h0654);
        expect_result("round", 9, 1'b1, 16'h0020, 5'd1, 16'h0080);

        mem[11'h68A] = 16'd1;
        mem[11'h1C8] = 16'hFFFF;
        run(1'b0, 16'hFFFF, 0, cyc);
        check("clamp_hcm_addr", hcm_seen, 16'h065C);
        expect_result("sat", 7, 1'b1, 16'hFFFF, 5'd0, 16'hFFFF);

        // 40 requested, 32 scanned; entries past the cap would otherwise win.
        mem[11'h68A] = 16'd40;
        for (int j = 0; j < 40; j++)
            mem[11'h1C8 + 11'(2 * j)] = (j < 32) ? 16'(16'h0100 - j) : 16'h0001;
        run(1'b0, 16'h0000, 0, cyc);
        check("cap_max_qaddr", max_qaddr, 16'h0206);
        check("cap_hcm_addr", hcm_seen, 16'h0648);
        expect_result("cap", 38, 1'b1, 16'h00E1, 5'd31, 16'h00E1);

        mem[11'h68A] = 16'd3;
        mem[11'h1C8] = 16'h0040; mem[11'h1CA] = 16'h0020; mem[11'h1CC] = 16'h0030;
        run(1'b0, 16'h4000, 3, cyc);
        check("inject_hcm_addr", hcm_seen, 16'h0652);
        expect_result("inject", 9, 1'b1, 16'h0020, 5'd1, 16'h0040);

        // Asynchronous reset in the middle of the scan.
        @(negedge clock);
        start = 1'b1; mode = 1'b0; battery = 16'h4000;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(negedge clock);
        check("abort_busy_before", busy, 1'b1);
        #2 rst = 1'b1;
        #1 check_reset_values("abort");
        #1 rst = 1'b0;

        run(1'b0, 16'h4000, 0, cyc);
        check("restart_hcm_addr", hcm_seen, 16'h0652);
        expect_result("restart", 9, 1'b1, 16'h0020, 5'd1, 16'h0040);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
